// File: rtl/hamming_pkg.sv
// Shared definitions for the Hamming min/max engine.
// Holds the operand geometry, the result write-back addresses, the
// distance width, the starting value of the running minimum, and the
// controller state type.
package hamming_pkg;

    localparam int NUM_WORDS = 32;
    localparam int NUM_BYTES = 64;

    localparam logic [7:0] MIN_ADDR = 8'd64;
    localparam logic [7:0] MAX_ADDR = 8'd65;

    localparam int DIST_W = 5;

    localparam logic [DIST_W-1:0] DIST_INIT_MIN = 5'd16;
    localparam logic [DIST_W-1:0] DIST_INIT_MAX = 5'd0;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        CMP    = 3'd2,
        WR_MIN = 3'd3,
        WR_MAX = 3'd4,
        DONE   = 3'd5
    } state_t;

endpackage

// File: rtl/hamming_minmax_engine_popcount16.sv
// popcount16: purely combinational population count.
// Ports:
//   din - 16-bit input word
//   cnt - number of set bits in din (0..16)
module popcount16 (
    input  logic [15:0] din,
    output logic [4:0]  cnt
);

    // Accumulate set bits one at a time.
    always_comb begin
        cnt = 5'd0;
        for (int i = 0; i < 16; i++) begin
            cnt = cnt + {4'd0, din[i]};
        end
    end

endmodule

// File: rtl/hamming_minmax_engine.sv
// hamming_minmax_engine
// After a 1->0 transition on req, the engine does three things in order:
//   - it loads 32 sixteen-bit words from data memory (bytes 0..63, high byte first);
//   - it computes the Hamming distance of every pair (j,k) with j<k;
//   - it writes the smallest distance to address 64 and the largest distance to address 65.
// It then raises done and holds it high until req returns high.
// Ports:
//   clk       - clock, rising edge
//   reset     - asynchronous active-high reset
//   req       - host request; a falling edge starts a run
//   done      - completion acknowledge
//   mem_raddr - memory read address
//   mem_rdata - memory read data (one cycle after mem_raddr)
//   mem_wen   - memory write enable (single-cycle pulse)
//   mem_waddr - memory write address
//   mem_wdata - memory write data (zero-extended distance)
//   min_dist  - minimum distance of the last completed run
//   max_dist  - maximum distance of the last completed run
module hamming_minmax_engine
    import hamming_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    output logic              done,
    output logic [7:0]        mem_raddr,
    input  logic [7:0]        mem_rdata,
    output logic              mem_wen,
    output logic [7:0]        mem_waddr,
    output logic [7:0]        mem_wdata,
    output logic [DIST_W-1:0] min_dist,
    output logic [DIST_W-1:0] max_dist
);

    state_t              state_r;
    logic                req_prev_r;
    logic [6:0]          load_cnt_r;
    logic [4:0]          j_r;
    logic [4:0]          k_r;
    logic [DIST_W-1:0]   run_min_r;
    logic [DIST_W-1:0]   run_max_r;
    logic [15:0]         wbuf_r [NUM_WORDS];

    logic                start_s;
    logic [5:0]          byte_idx_s;
    logic [DIST_W-1:0]   dist_s;
    logic [DIST_W-1:0]   min_next_s;
    logic [DIST_W-1:0]   max_next_s;
    logic [15:0]         diff_s;

    // Start only on a registered high followed by a low, and only while idle.
    assign start_s = (state_r == IDLE) && !req && req_prev_r;

    // The byte arriving on mem_rdata belongs to the address issued one cycle earlier.
    assign byte_idx_s = 6'(load_cnt_r - 7'd1);

    assign diff_s = wbuf_r[j_r] ^ wbuf_r[k_r];

    popcount16 u_popcount (
        .din (diff_s),
        .cnt (dist_s)
    );

    // Next running min/max; strict comparisons so ties keep the first pair.
    always_comb begin
        min_next_s = run_min_r;
        max_next_s = run_max_r;
        if (dist_s < run_min_r) begin
            min_next_s = dist_s;
        end else begin
            min_next_s = run_min_r;
        end
        if (dist_s > run_max_r) begin
            max_next_s = dist_s;
        end else begin
            max_next_s = run_max_r;
        end
    end

    // Operand buffer: capture each returning byte into its word half.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                wbuf_r[i] <= 16'd0;
            end
        end else if ((state_r == LOAD) && (load_cnt_r != 7'd0)) begin
            if (byte_idx_s[0] == 1'b0) begin
                wbuf_r[byte_idx_s[5:1]][15:8] <= mem_rdata;
            end else begin
                wbuf_r[byte_idx_s[5:1]][7:0] <= mem_rdata;
            end
        end
    end

    // Controller FSM with all outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            req_prev_r <= 1'b1;
            done       <= 1'b0;
            mem_raddr  <= 8'd0;
            mem_wen    <= 1'b0;
            mem_waddr  <= 8'd0;
            mem_wdata  <= 8'd0;
            min_dist   <= DIST_INIT_MIN;
            max_dist   <= DIST_INIT_MAX;
            load_cnt_r <= 7'd0;
            j_r        <= 5'd0;
            k_r        <= 5'd0;
            run_min_r  <= DIST_INIT_MIN;
            run_max_r  <= DIST_INIT_MAX;
        end else begin
            // Sampled in every state, so a fresh falling edge is only seen from IDLE.
            req_prev_r <= req;
            mem_wen    <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start_s) begin
                        state_r    <= LOAD;
                        load_cnt_r <= 7'd0;
                        mem_raddr  <= 8'd0;
                        j_r        <= 5'd0;
                        k_r        <= 5'd1;
                        run_min_r  <= DIST_INIT_MIN;
                        run_max_r  <= DIST_INIT_MAX;
                    end
                end
                LOAD: begin
                    // Addresses 0..63 go out in cycles 0..63; cycle 64 only drains the last byte.
                    if (load_cnt_r < 7'd63) begin
                        mem_raddr <= mem_raddr + 8'd1;
                    end
                    if (load_cnt_r == 7'd64) begin
                        state_r    <= CMP;
                        load_cnt_r <= 7'd0;
                    end else begin
                        load_cnt_r <= load_cnt_r + 7'd1;
                    end
                end
                CMP: begin
                    run_min_r <= min_next_s;
                    run_max_r <= max_next_s;
                    if ((j_r == 5'd30) && (k_r == 5'd31)) begin
                        // Include the final pair's result in the minimum write.
                        state_r   <= WR_MIN;
                        mem_wen   <= 1'b1;
                        mem_waddr <= MIN_ADDR;
                        mem_wdata <= {3'd0, min_next_s};
                    end else if (k_r == 5'd31) begin
                        j_r <= j_r + 5'd1;
                        k_r <= j_r + 5'd2;
                    end else begin
                        k_r <= k_r + 5'd1;
                    end
                end
                WR_MIN: begin
                    state_r   <= WR_MAX;
                    mem_wen   <= 1'b1;
                    mem_waddr <= MAX_ADDR;
                    mem_wdata <= {3'd0, run_max_r};
                end
                WR_MAX: begin
                    state_r  <= DONE;
                    done     <= 1'b1;
                    min_dist <= run_min_r;
                    max_dist <= run_max_r;
                end
                DONE: begin
                    if (req) begin
                        state_r <= IDLE;
                        done    <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hamming_minmax_engine.sv
`timescale 1ns/1ps
module tb_hamming_minmax_engine;

    logic       clk;
    logic       reset;
    logic       req;
    logic       done;
    logic [7:0] mem_raddr;
    logic [7:0] mem_rdata;
    logic       mem_wen;
    logic [7:0] mem_waddr;
    logic [7:0] mem_wdata;
    logic [4:0] min_dist;
    logic [4:0] max_dist;

    logic       tb_we;
    logic [7:0] tb_addr;
    logic [7:0] tb_data;

    logic [7:0] mem [256];
    int         wr_count;
    int         bad_wr;
    int         checks;
    int         errors;

    hamming_minmax_engine dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .done      (done),
        .mem_raddr (mem_raddr),
        .mem_rdata (mem_rdata),
        .mem_wen   (mem_wen),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .min_dist  (min_dist),
        .max_dist  (max_dist)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        wr_count = 0;
        bad_wr   = 0;
    end

    // Synchronous-read data memory with a bench-side preload port.
    always @(posedge clk) begin
        mem_rdata <= mem[mem_raddr];
        if (tb_we) begin
            mem[tb_addr] <= tb_data;
        end else if (mem_wen) begin
            mem[mem_waddr] <= mem_wdata;
        end
        if (mem_wen) begin
            wr_count <= wr_count + 1;
            if (mem_waddr != 8'd64 && mem_waddr != 8'd65) begin
                bad_wr <= bad_wr + 1;
            end
        end
    end

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic poke(input int a, input int d);
        @(negedge clk);
        tb_we   = 1'b1;
        tb_addr = 8'(a);
        tb_data = 8'(d);
        @(negedge clk);
        tb_we   = 1'b0;
    endtask

    task automatic set_word(input int i, input int w);
        poke(2 * i, (w >> 8) & 255);
        poke(2 * i + 1, w & 255);
    endtask

    // Drop req, treat the next rising edge as the start edge, and count edges until done.
    task automatic run_op(output int lat);
        @(negedge clk);
        req = 1'b0;
        @(posedge clk);
        #1;
        lat = 0;
        while (done !== 1'b1 && lat < 1000) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic release_req();
        @(negedge clk);
        req = 1'b1;
        @(posedge clk);
        #1;
    endtask

    int lat;
    int wr0;

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        req    = 1'b1;
        tb_we  = 1'b0;
        tb_addr = 8'd0;
        tb_data = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_done", int'(done), 0);
        check_eq("rst_wen", int'(mem_wen), 0);
        check_eq("rst_raddr", int'(mem_raddr), 0);
        check_eq("rst_waddr", int'(mem_waddr), 0);
        check_eq("rst_wdata", int'(mem_wdata), 0);
        check_eq("rst_min", int'(min_dist), 16);
        check_eq("rst_max", int'(max_dist), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("idle_done", int'(done), 0);

        // All bytes zero.
        for (int i = 0; i < 64; i++) poke(i, 0);
        poke(64, 8'hAA);
        poke(65, 8'hAA);
        wr0 = wr_count;
        run_op(lat);
        check_eq("zero_lat", lat, 563);
        check_eq("zero_m64", int'(mem[64]), 0);
        check_eq("zero_m65", int'(mem[65]), 0);
        check_eq("zero_min", int'(min_dist), 0);
        check_eq("zero_max", int'(max_dist), 0);
        check_eq("zero_wrs", wr_count - wr0, 2);
        release_req();
        check_eq("zero_done_fall", int'(done), 0);

        // One all-ones word among zeros.
        set_word(0, 16'hFFFF);
        poke(64, 8'hAA);
        poke(65, 8'hAA);
        run_op(lat);
        check_eq("ones_lat", lat, 563);
        check_eq("ones_m64", int'(mem[64]), 0);
        check_eq("ones_m65", int'(mem[65]), 16);
        check_eq("ones_max", int'(max_dist), 16);
        release_req();

        // W[i] = i.
        for (int i = 0; i < 32; i++) set_word(i, i);
        poke(64, 8'hAA);
        poke(65, 8'hAA);
        run_op(lat);
        check_eq("ramp_lat", lat, 563);
        check_eq("ramp_m64", int'(mem[64]), 1);
        check_eq("ramp_m65", int'(mem[65]), 5);
        check_eq("ramp_min", int'(min_dist), 1);
        check_eq("ramp_max", int'(max_dist), 5);
        release_req();

        // Reset in the middle of the compare phase.
        poke(64, 16);
        poke(65, 0);
        wr0 = wr_count;
        @(negedge clk);
        req = 1'b0;
        repeat (300) @(posedge clk);
        @(negedge clk);
        req   = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (600) @(posedge clk);
        #1;
        check_eq("abort_done", int'(done), 0);
        check_eq("abort_m64", int'(mem[64]), 16);
        check_eq("abort_m65", int'(mem[65]), 0);
        check_eq("abort_wrs", wr_count - wr0, 0);
        check_eq("abort_min", int'(min_dist), 16);
        check_eq("abort_max", int'(max_dist), 0);
        run_op(lat);
        check_eq("rerun_lat", lat, 563);
        check_eq("rerun_m64", int'(mem[64]), 1);
        check_eq("rerun_m65", int'(mem[65]), 5);

        // Hold req low long after done, then release.
        wr0 = wr_count;
        repeat (2000) @(posedge clk);
        #1;
        check_eq("hold_done", int'(done), 1);
        release_req();
        check_eq("hold_done_fall", int'(done), 0);
        repeat (50) @(posedge clk);
        #1;
        check_eq("hold_no_rerun_done", int'(done), 0);
        check_eq("hold_no_rerun_wrs", wr_count - wr0, 0);
        check_eq("hold_no_rerun_raddr", int'(mem_raddr), 63);

        // Toggle req throughout the run; it must be ignored.
        for (int i = 0; i < 32; i++) set_word(i, (i == 0) ? 16'hFFFF : 16'h0000);
        poke(64, 8'hAA);
        poke(65, 8'hAA);
        @(negedge clk);
        req = 1'b0;
        @(posedge clk);
        #1;
        lat = 0;
        while (done !== 1'b1 && lat < 1000) begin
            @(negedge clk);
            if (lat >= 100 && lat < 400) req = ~req;
            else if (lat >= 400) req = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq("tog_lat", lat, 563);
        check_eq("tog_m64", int'(mem[64]), 0);
        check_eq("tog_m65", int'(mem[65]), 16);
        check_eq("tog_max", int'(max_dist), 16);
        release_req();

        check_eq("bad_write_addr", bad_wr, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
